// File: rtl/mips_cpu_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with Avalon waitrequest stalls and a bus watchdog.
// Optional performance counters are enabled by defining CTRL_PERF_CNT_EN.
module mips_cpu_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        sig_branch,
  input  logic        jr_target_zero,
  input  logic        mem_waitrequest,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        active,
  output logic        bus_error,
  output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instr_retired,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg;
  logic        bus_error_reg;
  logic        in_access;
  logic        timeout;
  logic        is_lw;
  logic        is_sw;
  logic        jr_halt;

  assign in_access = (state_reg == S_FETCH) || (state_reg == S_MEM);
  // Timeout is decided by the counter alone, so a waitrequest dropping on that cycle is ignored.
  assign timeout   = in_access && (MEM_TIMEOUT != 0) && (32'(wait_cnt_reg) == MEM_TIMEOUT);
  assign is_lw     = (opcode == 6'h23);
  assign is_sw     = (opcode == 6'h2B);
  assign state     = state_reg;
  assign bus_error = bus_error_reg | timeout;

  always_comb begin
    state_next = state_reg;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    active     = 1'b0;
    jr_halt    = 1'b0;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        active = 1'b1;
        if (timeout) begin
          state_next = S_HALT;
        end else begin
          mem_read = 1'b1;
          if (!mem_waitrequest) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        active     = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        active = 1'b1;
        case (opcode)
          6'h00: begin
            if (funct == 6'h08) begin
              if (jr_target_zero) begin
                jr_halt    = 1'b1;
                state_next = S_HALT;
              end else begin
                pc_write   = 1'b1;
                pc_src     = 2'd3;
                state_next = S_FETCH;
              end
            end else begin
              state_next = S_WB;
            end
          end
          6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: state_next = S_WB;
          6'h04, 6'h05: begin
            pc_write   = sig_branch;
            pc_src     = 2'd1;
            state_next = S_FETCH;
          end
          6'h02: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            state_next = S_FETCH;
          end
          6'h03: begin
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            state_next = S_WB;
          end
          6'h23, 6'h2B: state_next = S_MEM;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        active = 1'b1;
        if (timeout) begin
          state_next = S_HALT;
        end else begin
          // IR is not reloaded until the next FETCH, so opcode still identifies lw/sw here.
          mem_read  = is_lw;
          mem_write = is_sw;
          if (!mem_waitrequest) state_next = is_lw ? S_WB : S_FETCH;
        end
      end
      S_WB: begin
        active     = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      wait_cnt_reg  <= 8'd0;
      bus_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bus_error_reg <= bus_error_reg | timeout;
      if ((state_next != state_reg) && ((state_next == S_FETCH) || (state_next == S_MEM)))
        wait_cnt_reg <= 8'd0;
      else if (in_access && mem_waitrequest && (wait_cnt_reg != 8'hFF))
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire;
  assign retire = jr_halt || ((state_next == S_FETCH) &&
                  ((state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= 32'd0;
      stall_cycles  <= 32'd0;
    end else begin
      if (retire) instr_retired <= instr_retired + 32'd1;
      if (in_access && mem_waitrequest) stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
